// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types for the pipeline hazard controller: sequencer states and register-address width.
package pipeline_pkg;

    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/pipeline_hazard_controller_saturating_counter.sv
// Up-counter that sticks at all-ones; one-cycle update, no backpressure.
module saturating_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             increment,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (increment && (count != '1)) begin
            count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the five-stage pipeline; controls are combinational in the same cycle,
// data-memory waits freeze the whole pipe until dmem_ready or timeout.
module pipeline_hazard_controller
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic                      id_usesRs,
    input  logic                      id_usesRt,
    input  logic                      ex_shouldWriteRegister,
    input  logic                      ex_shouldWriteMemoryElseAluOutputToRegister,
    input  logic [REG_ADDR_WIDTH-1:0] ex_registerWriteAddress,
    input  logic                      ex_branchTaken,
    input  logic                      mem_isMemoryAccess,
    input  logic                      dmem_ready,
    output logic                      dmem_request,
    output logic                      pc_stall,
    output logic                      ifid_stall,
    output logic                      idex_stall,
    output logic                      exmem_stall,
    output logic                      ifid_flush,
    output logic                      idex_flush,
    output logic                      memwb_flush,
    output logic                      memError,
    output logic [COUNT_WIDTH-1:0]    stallCycleCount,
    output logic [COUNT_WIDTH-1:0]    flushCount
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT);

    hazard_state_t state;
    logic [7:0]    wait_count;
    logic          freeze;
    logic          branch_flush;
    logic          load_use;
    logic          load_use_hit;

    assign load_use_hit = ex_shouldWriteMemoryElseAluOutputToRegister & ex_shouldWriteRegister
                        & (ex_registerWriteAddress != '0)
                        & ((id_usesRs & (id_rs == ex_registerWriteAddress))
                         | (id_usesRt & (id_rt == ex_registerWriteAddress)));

    // Outputs are forced low while reset is held so an aborted access drops its request at once.
    always_comb begin
        freeze       = 1'b0;
        dmem_request = 1'b0;
        if (!reset) begin
            case (state)
                RUN: begin
                    dmem_request = mem_isMemoryAccess;
                    freeze       = mem_isMemoryAccess & ~dmem_ready;
                end
                MEM_WAIT: begin
                    dmem_request = 1'b1;
                    freeze       = ~dmem_ready;
                end
                ERROR:   freeze = 1'b1;
                default: freeze = 1'b0;
            endcase
        end
    end

    // EX is held during a freeze, so branches and load-use are re-evaluated once it lifts.
    always_comb begin
        branch_flush = !reset && (state == RUN) && !freeze && ex_branchTaken;
        load_use     = !reset && (state == RUN) && !freeze && !ex_branchTaken && load_use_hit;
        pc_stall     = freeze | load_use;
        ifid_stall   = freeze | load_use;
        idex_stall   = freeze;
        exmem_stall  = freeze;
        ifid_flush   = branch_flush;
        idex_flush   = branch_flush | load_use;
        memwb_flush  = freeze;
        memError     = !reset && (state == ERROR);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            wait_count <= 8'd0;
        end else begin
            case (state)
                RUN: begin
                    if (freeze) begin
                        wait_count <= 8'd1;
                        state      <= (TIMEOUT_LAST == 8'd1) ? ERROR : MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state <= RUN;
                    end else begin
                        wait_count <= wait_count + 8'd1;
                        if ((wait_count + 8'd1) == TIMEOUT_LAST) begin
                            state <= ERROR;
                        end
                    end
                end
                ERROR:   state <= ERROR;
                default: state <= RUN;
            endcase
        end
    end

    saturating_counter #(.WIDTH(COUNT_WIDTH)) u_stall_counter (
        .clock     (clock),
        .reset     (reset),
        .increment (pc_stall | ifid_stall | idex_stall | exmem_stall),
        .count     (stallCycleCount)
    );

    saturating_counter #(.WIDTH(COUNT_WIDTH)) u_flush_counter (
        .clock     (clock),
        .reset     (reset),
        .increment (branch_flush),
        .count     (flushCount)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed-vector bench for pipeline_hazard_controller (MEM_TIMEOUT=4, 4-bit counters).
module tb_pipeline_hazard_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs, id_rt, ex_registerWriteAddress;
    logic       id_usesRs, id_usesRt, ex_shouldWriteRegister;
    logic       ex_shouldWriteMemoryElseAluOutputToRegister, ex_branchTaken;
    logic       mem_isMemoryAccess, dmem_ready;
    logic       dmem_request, pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic       ifid_flush, idex_flush, memwb_flush, memError;
    logic [3:0] stallCycleCount, flushCount;
    logic [8:0] ctl;

    int vectors = 0;
    int miscompares = 0;

    // Expected control patterns {req, pc_s, ifid_s, idex_s, exmem_s, ifid_f, idex_f, memwb_f, err}
    localparam logic [8:0] IDLE     = 9'b000000000;
    localparam logic [8:0] LOADUSE  = 9'b011000100;
    localparam logic [8:0] BRANCH   = 9'b000001100;
    localparam logic [8:0] FREEZE   = 9'b111110010;
    localparam logic [8:0] ERRFRZ   = 9'b011110011;
    localparam logic [8:0] REQONLY  = 9'b100000000;

    pipeline_hazard_controller #(.MEM_TIMEOUT(4), .COUNT_WIDTH(4)) dut (
        .clock                                       (clock),
        .reset                                       (reset),
        .id_rs                                       (id_rs),
        .id_rt                                       (id_rt),
        .id_usesRs                                   (id_usesRs),
        .id_usesRt                                   (id_usesRt),
        .ex_shouldWriteRegister                      (ex_shouldWriteRegister),
        .ex_shouldWriteMemoryElseAluOutputToRegister (ex_shouldWriteMemoryElseAluOutputToRegister),
        .ex_registerWriteAddress                     (ex_registerWriteAddress),
        .ex_branchTaken                              (ex_branchTaken),
        .mem_isMemoryAccess                          (mem_isMemoryAccess),
        .dmem_ready                                  (dmem_ready),
        .dmem_request                                (dmem_request),
        .pc_stall                                    (pc_stall),
        .ifid_stall                                  (ifid_stall),
        .idex_stall                                  (idex_stall),
        .exmem_stall                                 (exmem_stall),
        .ifid_flush                                  (ifid_flush),
        .idex_flush                                  (idex_flush),
        .memwb_flush                                 (memwb_flush),
        .memError                                    (memError),
        .stallCycleCount                             (stallCycleCount),
        .flushCount                                  (flushCount)
    );

    assign ctl = {dmem_request, pc_stall, ifid_stall, idex_stall, exmem_stall,
                  ifid_flush, idex_flush, memwb_flush, memError};

    always #5 clock = ~clock;

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                         input logic wr, input logic ld, input logic [4:0] wa,
                         input logic br, input logic mem, input logic rdy);
        id_rs = rs; id_rt = rt; id_usesRs = urs; id_usesRt = urt;
        ex_shouldWriteRegister = wr; ex_shouldWriteMemoryElseAluOutputToRegister = ld;
        ex_registerWriteAddress = wa; ex_branchTaken = br;
        mem_isMemoryAccess = mem; dmem_ready = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
        vectors++;
        if (ctl !== IDLE || stallCycleCount !== 4'd0 || flushCount !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_hold ctl=%b stall=%0d flush=%0d want ctl=%b 0 0", ctl, stallCycleCount, flushCount, IDLE);
        end
        tick();
        reset = 1'b0;
        #1;
        tick();
        vectors++;
        if (ctl !== IDLE || stallCycleCount !== 4'd0 || flushCount !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_idle ctl=%b stall=%0d flush=%0d want ctl=%b 0 0", ctl, stallCycleCount, flushCount, IDLE);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 0, 0, 0);
        vectors++;
        if (ctl !== LOADUSE) begin
            miscompares++; $display("FAIL loaduse_rs ctl=%b want %b", ctl, LOADUSE);
        end
        tick();
        drive(5'd5, 5'd0, 1, 0, 0, 0, 5'd0, 0, 0, 0);
        vectors++;
        if (ctl !== IDLE || stallCycleCount !== 4'd1) begin
            miscompares++; $display("FAIL loaduse_once ctl=%b stall=%0d want %b 1", ctl, stallCycleCount, IDLE);
        end
        drive(5'd0, 5'd0, 1, 1, 1, 1, 5'd0, 0, 0, 0);
        vectors++;
        if (ctl !== IDLE) begin
            miscompares++; $display("FAIL loaduse_r0 ctl=%b want %b", ctl, IDLE);
        end
        drive(5'd3, 5'd9, 1, 1, 1, 0, 5'd9, 0, 0, 0);
        vectors++;
        if (ctl !== IDLE) begin
            miscompares++; $display("FAIL alu_write_no_stall ctl=%b want %b", ctl, IDLE);
        end
        drive(5'd3, 5'd9, 1, 0, 1, 1, 5'd9, 0, 0, 0);
        vectors++;
        if (ctl !== IDLE) begin
            miscompares++; $display("FAIL rt_unused ctl=%b want %b", ctl, IDLE);
        end
        drive(5'd3, 5'd9, 1, 1, 1, 1, 5'd9, 0, 0, 0);
        vectors++;
        if (ctl !== LOADUSE) begin
            miscompares++; $display("FAIL loaduse_rt ctl=%b want %b", ctl, LOADUSE);
        end
        tick();
        drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
        vectors++;
        if (stallCycleCount !== 4'd2 || flushCount !== 4'd0) begin
            miscompares++; $display("FAIL loaduse_counts stall=%0d flush=%0d want 2 0", stallCycleCount, flushCount);
        end
    endtask

    task automatic test_branch();
        do_reset();
        drive(5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 1, 0, 0);
        vectors++;
        if (ctl !== BRANCH) begin
            miscompares++; $display("FAIL branch_over_loaduse ctl=%b want %b", ctl, BRANCH);
        end
        tick();
        drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
        vectors++;
        if (ctl !== IDLE || flushCount !== 4'd1 || stallCycleCount !== 4'd0) begin
            miscompares++;
            $display("FAIL branch_counts ctl=%b flush=%0d stall=%0d want %b 1 0", ctl, flushCount, stallCycleCount, IDLE);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(5'd5, 5'd0, 1, 0, 1, 1, 5'd5, (c == 1), 1, 0);
            vectors++;
            if (ctl !== FREEZE) begin
                miscompares++; $display("FAIL memwait_freeze cycle=%0d ctl=%b want %b", c, ctl, FREEZE);
            end
            tick();
        end
        drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 1);
        vectors++;
        if (ctl !== REQONLY) begin
            miscompares++; $display("FAIL memwait_ready ctl=%b want %b", ctl, REQONLY);
        end
        tick();
        drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
        vectors++;
        if (ctl !== IDLE || stallCycleCount !== 4'd3 || flushCount !== 4'd0) begin
            miscompares++;
            $display("FAIL memwait_run ctl=%b stall=%0d flush=%0d want %b 3 0", ctl, stallCycleCount, flushCount, IDLE);
        end
        drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 1);
        vectors++;
        if (ctl !== REQONLY) begin
            miscompares++; $display("FAIL zero_wait ctl=%b want %b", ctl, REQONLY);
        end
        tick();
        drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
        vectors++;
        if (stallCycleCount !== 4'd3) begin
            miscompares++; $display("FAIL zero_wait_count stall=%0d want 3", stallCycleCount);
        end
    endtask

    // Timeout followed by a long ERROR freeze, which also drives the 4-bit stall counter into saturation.
    task automatic test_timeout_saturation();
        int exp_cnt;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 0);
            vectors++;
            if (ctl !== FREEZE) begin
                miscompares++; $display("FAIL timeout_wait cycle=%0d ctl=%b want %b", c, ctl, FREEZE);
            end
            tick();
        end
        for (int c = 0; c < 20; c++) begin
            drive(5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 1, 0, 1);
            exp_cnt = (4 + c > 15) ? 15 : 4 + c;
            vectors++;
            if (ctl !== ERRFRZ || stallCycleCount !== 4'(exp_cnt)) begin
                miscompares++;
                $display("FAIL error_freeze cycle=%0d ctl=%b stall=%0d want %b %0d", c, ctl, stallCycleCount, ERRFRZ, exp_cnt);
            end
            tick();
        end
        vectors++;
        if (flushCount !== 4'd0) begin
            miscompares++; $display("FAIL error_no_flush flush=%0d want 0", flushCount);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 0);
        tick();
        tick();
        vectors++;
        if (ctl !== FREEZE || stallCycleCount !== 4'd2) begin
            miscompares++; $display("FAIL mid_before ctl=%b stall=%0d want %b 2", ctl, stallCycleCount, FREEZE);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (ctl !== IDLE || stallCycleCount !== 4'd0 || flushCount !== 4'd0) begin
            miscompares++;
            $display("FAIL mid_async ctl=%b stall=%0d flush=%0d want %b 0 0", ctl, stallCycleCount, flushCount, IDLE);
        end
        tick();
        reset = 1'b0;
        drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 1);
        vectors++;
        if (ctl !== REQONLY) begin
            miscompares++; $display("FAIL mid_zero_wait ctl=%b want %b", ctl, REQONLY);
        end
        tick();
        drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
        vectors++;
        if (ctl !== IDLE || stallCycleCount !== 4'd0) begin
            miscompares++; $display("FAIL mid_after ctl=%b stall=%0d want %b 0", ctl, stallCycleCount, IDLE);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
